// File: rtl/mem_access_if.sv
// EX/MEM inputs, data-memory handshake and MEM/WB outputs of the memory-access stage.
// The master modport is the stage's view; the slave modport is the surrounding pipeline and memory.
interface mem_access_if #(
  parameter int PC_WIDTH      = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int REGADDR_WIDTH = 4
);
  logic                     mem_reg_write;
  logic                     mem_mem_read;
  logic                     mem_mem_write;
  logic [PC_WIDTH-1:0]      mem_pc;
  logic [DATA_WIDTH-1:0]    mem_alu_result;
  logic [DATA_WIDTH-1:0]    mem_write_data;
  logic [REGADDR_WIDTH-1:0] mem_rd;
  logic                     mem_is_jal;
  logic [DATA_WIDTH-1:0]    mem_jal_link_value;

  logic                     dmem_req;
  logic                     dmem_we;
  logic [DATA_WIDTH-1:0]    dmem_addr;
  logic [DATA_WIDTH-1:0]    dmem_wdata;
  logic                     dmem_ready;
  logic [DATA_WIDTH-1:0]    dmem_rdata;

  logic                     mem_stall;
  logic                     wb_reg_write;
  logic [REGADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]    wb_data;
  logic                     dmem_err;
  logic [PC_WIDTH-1:0]      dmem_err_pc;

  modport master (
    input  mem_reg_write, mem_mem_read, mem_mem_write, mem_pc, mem_alu_result,
           mem_write_data, mem_rd, mem_is_jal, mem_jal_link_value,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata,
    output mem_stall, wb_reg_write, wb_rd, wb_data, dmem_err, dmem_err_pc
  );

  modport slave (
    output mem_reg_write, mem_mem_read, mem_mem_write, mem_pc, mem_alu_result,
           mem_write_data, mem_rd, mem_is_jal, mem_jal_link_value,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata,
    input  mem_stall, wb_reg_write, wb_rd, wb_data, dmem_err, dmem_err_pc
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage: data-memory req/ready access, front-end stall, MEM/WB register.
// Define MEM_ACCESS_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES without dmem_ready.
module mem_access_stage #(
  parameter int PC_WIDTH       = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int REGADDR_WIDTH  = 4
`ifdef MEM_ACCESS_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 15
`endif
) (
  input logic         clk,
  input logic         reset,
  mem_access_if.master bus
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                   r_state;
  logic                     r_we;
  logic [DATA_WIDTH-1:0]    r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic                     r_wb_reg_write;
  logic [REGADDR_WIDTH-1:0] r_wb_rd;
  logic [DATA_WIDTH-1:0]    r_wb_data;

  logic                     w_access;
  logic                     w_is_load;
  logic                     w_in_wait;
  logic                     w_req;
  logic                     w_stall;
  logic                     w_timeout;
  logic [DATA_WIDTH-1:0]    w_wb_sel;

  function automatic logic [DATA_WIDTH-1:0] f_wb_select(
    input logic                  is_jal,
    input logic                  is_load,
    input logic [DATA_WIDTH-1:0] link,
    input logic [DATA_WIDTH-1:0] rdata,
    input logic [DATA_WIDTH-1:0] alu
  );
    if (is_jal)       return link;
    else if (is_load) return rdata;
    else              return alu;
  endfunction

  // A store wins over a load when both flags are set.
  assign w_access  = bus.mem_mem_read | bus.mem_mem_write;
  assign w_is_load = bus.mem_mem_read & ~bus.mem_mem_write;
  assign w_in_wait = (r_state == S_WAIT);
  assign w_req     = ~reset & (w_in_wait | w_access);
  assign w_stall   = w_req & ~bus.dmem_ready & ~w_timeout;
  assign w_wb_sel  = f_wb_select(bus.mem_is_jal, w_is_load, bus.mem_jal_link_value,
                                 bus.dmem_rdata, bus.mem_alu_result);

  assign bus.dmem_req   = w_req;
  assign bus.dmem_we    = w_in_wait ? r_we    : bus.mem_mem_write;
  assign bus.dmem_addr  = w_in_wait ? r_addr  : bus.mem_alu_result;
  assign bus.dmem_wdata = w_in_wait ? r_wdata : bus.mem_write_data;
  assign bus.mem_stall  = w_stall;

  assign bus.wb_reg_write = r_wb_reg_write;
  assign bus.wb_rd        = r_wb_rd;
  assign bus.wb_data      = r_wb_data;

  // Request capture: frozen copies drive the memory for the whole WAIT period.
  always_ff @(posedge clk) begin
    if (!w_in_wait && w_access) begin
      r_we    <= bus.mem_mem_write;
      r_addr  <= bus.mem_alu_result;
      r_wdata <= bus.mem_write_data;
    end
  end

  // FSM and MEM/WB register: stalled or aborted cycles write a bubble and hold rd/data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_wb_reg_write <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_data      <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_access && !bus.dmem_ready) r_state <= S_WAIT;
        S_WAIT:  if (bus.dmem_ready || w_timeout) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_stall || w_timeout) begin
        r_wb_reg_write <= 1'b0;
      end else begin
        r_wb_reg_write <= bus.mem_reg_write & (|bus.mem_rd);
        r_wb_rd        <= bus.mem_rd;
        r_wb_data      <= w_wb_sel;
      end
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;
  logic [PC_WIDTH-1:0] r_err_pc;

  // Abort on the WAIT cycle that would bring the count to TIMEOUT_CYCLES; ready in that cycle wins.
  assign w_timeout = w_in_wait & ~bus.dmem_ready & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_err_pc <= '0;
    end else begin
      r_err <= w_timeout;
      if (w_timeout) r_err_pc <= bus.mem_pc;
      if (!w_in_wait || bus.dmem_ready || w_timeout) r_cnt <= '0;
      else                                            r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.dmem_err    = r_err;
  assign bus.dmem_err_pc = r_err_pc;
`else
  logic w_unused_pc;

  assign w_timeout       = 1'b0;
  assign w_unused_pc     = ^bus.mem_pc;
  assign bus.dmem_err    = 1'b0;
  assign bus.dmem_err_pc = '0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage with an instruction-level reference model and directed pins.
`timescale 1ns/1ps
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_if bus();
  mem_access_stage dut (.clk(clk), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int stall_cnt = 0;
  bit chk_en   = 1'b0;

  // Model state: expected handshake for the current cycle and expected MEM/WB contents.
  logic        m_req, m_stall, m_we;
  logic [15:0] m_addr, m_wdata;
  logic        m_wb_we;
  logic [3:0]  m_wb_rd;
  logic [15:0] m_wb_data;
  logic [15:0] m_err_pc = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dmem_req", bus.dmem_req, m_req);
      chk("mem_stall", bus.mem_stall, m_stall);
      if (m_req) begin
        chk("dmem_we", bus.dmem_we, m_we);
        chk("dmem_addr", bus.dmem_addr, m_addr);
        chk("dmem_wdata", bus.dmem_wdata, m_wdata);
      end
      chk("wb_reg_write", bus.wb_reg_write, m_wb_we);
      chk("wb_rd", bus.wb_rd, m_wb_rd);
      chk("wb_data", bus.wb_data, m_wb_data);
      chk("dmem_err", bus.dmem_err, 1'b0);
      chk("dmem_err_pc", bus.dmem_err_pc, m_err_pc);
      if (bus.mem_stall) stall_cnt++;
    end
  end

  task automatic set_inputs(input logic rw, input logic mr, input logic mw, input logic [15:0] pc,
                            input logic [15:0] alu, input logic [15:0] wd, input logic [3:0] rd,
                            input logic jal, input logic [15:0] link);
    bus.mem_reg_write      = rw;
    bus.mem_mem_read       = mr;
    bus.mem_mem_write      = mw;
    bus.mem_pc             = pc;
    bus.mem_alu_result     = alu;
    bus.mem_write_data     = wd;
    bus.mem_rd             = rd;
    bus.mem_is_jal         = jal;
    bus.mem_jal_link_value = link;
  endtask

  // One instruction held in EX/MEM until it completes; memory answers after nwait low-ready cycles.
  // Called and returns 1 time unit after a rising edge.
  task automatic issue(input logic rw, input logic mr, input logic mw, input logic [15:0] pc,
                       input logic [15:0] alu, input logic [15:0] wd, input logic [3:0] rd,
                       input logic jal, input logic [15:0] link, input int nwait,
                       input logic [15:0] rdata);
    logic acc;
    int   n;
    acc = mr | mw;
    n   = acc ? nwait : 0;
    set_inputs(rw, mr, mw, pc, alu, wd, rd, jal, link);
    for (int k = 0; k <= n; k++) begin
      if (acc) begin
        bus.dmem_ready = (k == n);
        bus.dmem_rdata = (k == n) ? rdata : 16'($urandom);
      end else begin
        bus.dmem_ready = 1'($urandom_range(0, 1));
        bus.dmem_rdata = 16'($urandom);
      end
      m_req   = acc;
      m_stall = acc && (k < n);
      m_we    = mw;
      m_addr  = alu;
      m_wdata = wd;
      @(posedge clk); #1;
      if (k < n) begin
        m_wb_we = 1'b0;
      end else begin
        m_wb_we   = rw && (rd != 4'd0);
        m_wb_rd   = rd;
        m_wb_data = jal ? link : ((mr && !mw) ? rdata : alu);
      end
    end
  endtask

  task automatic nop_inputs();
    set_inputs(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 4'd0, 1'b0, 16'h0);
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 16'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: request must stay low even with a load presented.
    reset = 1'b1;
    set_inputs(1'b1, 1'b1, 1'b0, 16'h0, 16'h0040, 16'h0, 4'd2, 1'b0, 16'h0);
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 16'h0;
    #12;
    chk("reset_dmem_req", bus.dmem_req, 1'b0);
    chk("reset_wb_reg_write", bus.wb_reg_write, 1'b0);
    chk("reset_wb_rd", bus.wb_rd, 4'd0);
    chk("reset_wb_data", bus.wb_data, 16'h0);
    chk("reset_dmem_err", bus.dmem_err, 1'b0);
    chk("reset_dmem_err_pc", bus.dmem_err_pc, 16'h0);
    nop_inputs();
    @(posedge clk); #2 reset = 1'b0;
    m_req = 1'b0; m_stall = 1'b0; m_we = 1'b0; m_addr = 16'h0; m_wdata = 16'h0;
    m_wb_we = 1'b0; m_wb_rd = 4'd0; m_wb_data = 16'h0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // ALU op.
    stall_cnt = 0;
    issue(1'b1, 1'b0, 1'b0, 16'h0004, 16'h1234, 16'h0, 4'd3, 1'b0, 16'h0, 0, 16'h0);
    chk("alu_wb_reg_write", bus.wb_reg_write, 1'b1);
    chk("alu_wb_rd", bus.wb_rd, 4'd3);
    chk("alu_wb_data", bus.wb_data, 16'h1234);
    chk("alu_stalls", stall_cnt, 0);

    // Load with two wait cycles.
    stall_cnt = 0;
    issue(1'b1, 1'b1, 1'b0, 16'h0008, 16'h0040, 16'h5555, 4'd5, 1'b0, 16'h0, 2, 16'hBEEF);
    chk("load_stalls", stall_cnt, 2);
    chk("load_wb_reg_write", bus.wb_reg_write, 1'b1);
    chk("load_wb_rd", bus.wb_rd, 4'd5);
    chk("load_wb_data", bus.wb_data, 16'hBEEF);

    // Zero-wait store.
    stall_cnt = 0;
    issue(1'b0, 1'b0, 1'b1, 16'h000C, 16'h0010, 16'h00AA, 4'd6, 1'b0, 16'h0, 0, 16'h0);
    chk("store_stalls", stall_cnt, 0);
    chk("store_wb_reg_write", bus.wb_reg_write, 1'b0);

    // Read and write together: store semantics, write-back of the ALU value.
    issue(1'b1, 1'b1, 1'b1, 16'h0010, 16'h0022, 16'h0033, 4'd4, 1'b0, 16'h0, 1, 16'hDEAD);
    chk("rw_wb_data", bus.wb_data, 16'h0022);

    // JAL with rd=1 and rd=0.
    issue(1'b1, 1'b0, 1'b0, 16'h0014, 16'h0100, 16'h0, 4'd1, 1'b1, 16'h0024, 0, 16'h0);
    chk("jal_wb_data", bus.wb_data, 16'h0024);
    chk("jal_wb_reg_write", bus.wb_reg_write, 1'b1);
    issue(1'b1, 1'b0, 1'b0, 16'h0018, 16'h0100, 16'h0, 4'd0, 1'b1, 16'h0024, 0, 16'h0);
    chk("jal_x0_wb_reg_write", bus.wb_reg_write, 1'b0);

    // Back-to-back zero-wait loads.
    stall_cnt = 0;
    for (int i = 0; i < 4; i++)
      issue(1'b1, 1'b1, 1'b0, 16'h0020, 16'(16'h0100 + i), 16'h0, 4'(7 + i), 1'b0, 16'h0, 0,
            16'(16'hA000 + i));
    chk("b2b_stalls", stall_cnt, 0);
    chk("b2b_last_data", bus.wb_data, 16'hA003);

    // Randomized instruction stream.
    for (int i = 0; i < 300; i++) begin
      int          kind;
      logic        rw, mr, mw, jal;
      logic [15:0] pc, alu, wd, link, rdata;
      logic [3:0]  rd;
      kind  = $urandom_range(0, 4);
      pc    = 16'($urandom);
      alu   = 16'($urandom);
      wd    = 16'($urandom);
      link  = 16'($urandom);
      rdata = 16'($urandom);
      rd    = 4'($urandom);
      rw = 1'b0; mr = 1'b0; mw = 1'b0; jal = 1'b0;
      case (kind)
        0: rw = 1'($urandom_range(0, 1));
        1: begin rw = 1'b1; mr = 1'b1; end
        2: mw = 1'b1;
        3: begin rw = 1'($urandom_range(0, 1)); mr = 1'b1; mw = 1'b1; end
        default: begin rw = 1'b1; jal = 1'b1; end
      endcase
      issue(rw, mr, mw, pc, alu, wd, rd, jal, link, $urandom_range(0, 3), rdata);
    end

    // Reset asserted in WAIT.
    chk_en = 1'b0;
    set_inputs(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0200, 16'h0, 4'd7, 1'b0, 16'h0);
    bus.dmem_ready = 1'b0;
    @(posedge clk); #1;
    chk("wait_req_before_reset", bus.dmem_req, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("reset_in_wait_req", bus.dmem_req, 1'b0);
    chk("reset_in_wait_wb_reg_write", bus.wb_reg_write, 1'b0);
    nop_inputs();
    @(posedge clk); #1;
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("post_reset_req", bus.dmem_req, 1'b0);
    chk("post_reset_stall", bus.mem_stall, 1'b0);
    chk("post_reset_wb_reg_write", bus.wb_reg_write, 1'b0);
    chk("post_reset_wb_rd", bus.wb_rd, 4'd0);
    chk("post_reset_wb_data", bus.wb_data, 16'h0);
    m_req = 1'b0; m_stall = 1'b0;
    m_wb_we = 1'b0; m_wb_rd = 4'd0; m_wb_data = 16'h0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    issue(1'b1, 1'b1, 1'b0, 16'h0034, 16'h0044, 16'h0, 4'd8, 1'b0, 16'h0, 1, 16'h7777);
    chk("after_reset_load_data", bus.wb_data, 16'h7777);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Timeout: memory never answers.
    begin
      int stalls;
      chk_en = 1'b0;
      stalls = 0;
      set_inputs(1'b1, 1'b1, 1'b0, 16'h0080, 16'h0300, 16'h0, 4'd9, 1'b0, 16'h0);
      bus.dmem_ready = 1'b0;
      #1;
      while (bus.mem_stall && stalls < 40) begin
        stalls++;
        @(posedge clk); #1;
      end
      chk("timeout_stall_cycles", stalls, 15);
      chk("timeout_req_abort_cycle", bus.dmem_req, 1'b1);
      nop_inputs();
      @(posedge clk); #1;
      chk("timeout_err_pulse", bus.dmem_err, 1'b1);
      chk("timeout_err_pc", bus.dmem_err_pc, 16'h0080);
      chk("timeout_wb_reg_write", bus.wb_reg_write, 1'b0);
      chk("timeout_req_dropped", bus.dmem_req, 1'b0);
      @(posedge clk); #1;
      chk("timeout_err_one_cycle", bus.dmem_err, 1'b0);
      m_err_pc = 16'h0080;
      m_req = 1'b0; m_stall = 1'b0;
      m_wb_we = 1'b0; m_wb_rd = 4'd0; m_wb_data = 16'h0;
      chk_en = 1'b1;
      issue(1'b1, 1'b0, 1'b0, 16'h0090, 16'h0055, 16'h0, 4'd2, 1'b0, 16'h0, 0, 16'h0);
    end
`endif

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
